// File: rtl/mix_columns_multicycle.sv
// mix_columns_multicycle
//   Forward AES MixColumns for the encryption datapath. Accepts one 128-bit
//   state through a valid/ready handshake, mixes COLS_PER_CYCLE columns per
//   BUSY cycle with shared per-column xtime logic and returns the mixed state
//   through a second valid/ready handshake. With mix_en_i=0 the state is
//   passed through unchanged (AES final round).
//
// Ports
//   clk_i     in   1    clock, rising edge
//   reset_i   in   1    synchronous, active-high reset
//   v_i       in   1    input state valid
//   ready_o   out  1    block can accept (transfer on v_i & ready_o)
//   mix_en_i  in   1    1: MixColumns, 0: pass-through
//   state_i   in   128  input state, column-major, byte k = state_i[127-8k -: 8]
//   v_o       out  1    result valid
//   ready_i   in   1    consumer accepts (transfer on v_o & ready_i)
//   data_o    out  128  result, same byte order as state_i
//
// Parameter
//   COLS_PER_CYCLE  1, 2 or 4 columns mixed per BUSY cycle

module mix_columns_multicycle #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         v_i,
    output logic         ready_o,
    input  logic         mix_en_i,
    input  logic [127:0] state_i,
    output logic         v_o,
    input  logic         ready_i,
    output logic [127:0] data_o
);

    localparam int N_BUSY = 4 / COLS_PER_CYCLE;
    localparam int COL_W  = (N_BUSY > 1) ? $clog2(N_BUSY) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_BUSY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [COL_W-1:0]    r_col;
    // Element 0 is the most significant word, so index c selects column c.
    logic [0:3][31:0]    r_in;
    logic [0:3][31:0]    r_res;
    logic [0:3][31:0]    w_busy_res;
    logic                r_mix_en;
    logic                w_accept;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] x0, x1, x2, x3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        x0 = xtime(a0);
        x1 = xtime(a1);
        x2 = xtime(a2);
        x3 = xtime(a3);
        // 3a is xtime(a)^a
        b0 = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
        b3 = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
        return {b0, b1, b2, b3};
    endfunction

    assign ready_o  = (r_state == IDLE) && !reset_i;
    assign v_o      = (r_state == DONE) && !reset_i;
    assign data_o   = r_res;
    assign w_accept = v_i && ready_o;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = mix_en_i ? BUSY : DONE;
            BUSY:    if (r_col == LAST_COL) w_next = DONE;
            DONE:    if (ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Only the current column group is rewritten; the rest of the result holds.
    always_comb begin
        w_busy_res = r_res;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            w_busy_res[2'(int'(r_col) * COLS_PER_CYCLE + j)] =
                r_mix_en ? mix_col(r_in[2'(int'(r_col) * COLS_PER_CYCLE + j)])
                         : r_in[2'(int'(r_col) * COLS_PER_CYCLE + j)];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= IDLE;
            r_col    <= '0;
            r_in     <= '0;
            r_res    <= '0;
            r_mix_en <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_in     <= state_i;
                        r_mix_en <= mix_en_i;
                        r_col    <= '0;
                        if (!mix_en_i) r_res <= state_i;
                    end
                end
                BUSY: begin
                    r_res <= w_busy_res;
                    r_col <= r_col + COL_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
